aes128_iter_core: RTL



---
 rtl/aes128_iter_core_if.sv | 22 ++
 rtl/aes128_iter_core.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/aes128_iter_core_if.sv
// Block-in / ciphertext-out handshake bundle for the iterative AES-128 core.
// The requester/consumer side uses master; the core uses slave.
interface aes128_iter_core_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] plaintext;
    logic [127:0] key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] ciphertext;
    logic         busy;

    modport master (
        output in_valid, plaintext, key, out_ready,
        input  in_ready, out_valid, ciphertext, busy
    );

    modport slave (
        input  in_valid, plaintext, key, out_ready,
        output in_ready, out_valid, ciphertext, busy
    );
endinterface

// File: rtl/aes128_iter_core.sv
// Iterative AES-128 encryptor: one shared round datapath over 10 cycles, round keys on the fly.
// Byte order matches the combinational aes128 (s[0,0] in [127:120], column-major).
module aes128_iter_core (
    input  logic              clk,
    input  logic              rst,
    aes128_iter_core_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    localparam logic [0:255][7:0] Sbox = {
        256'h637c777bf26b6fc53001672bfed7ab76ca82c97dfa5947f0add4a2af9ca472c0,
        256'hb7fd9326363ff7cc34a5e5f171d8311504c723c31896059a071280e2eb27b275,
        256'h09832c1a1b6e5aa0523bd6b329e32f8453d100ed20fcb15b6acbbe394a4c58cf,
        256'hd0efaafb434d338545f9027f503c9fa851a3408f929d38f5bcb6da2110fff3d2,
        256'hcd0c13ec5f974417c4a77e3d645d197360814fdc222a908846eeb814de5e0bdb,
        256'he0323a0a4906245cc2d3ac629195e479e7c8376d8dd54ea96c56f4ea657aae08,
        256'hba78252e1ca6b4c6e8dd741f4bbd8b8a703eb5664803f60e613557b986c11d9e,
        256'he1f8981169d98e949b1e87e9ce5528df8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return Sbox[b];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
        return o;
    endfunction

    // Row r of column c takes the byte from column (c + r) mod 4.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) o[127-32*c -: 32] = mix_col(s[127-32*c -: 32]);
        return o;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] v;
        case (r)
            4'd1:    v = 8'h01;
            4'd2:    v = 8'h02;
            4'd3:    v = 8'h04;
            4'd4:    v = 8'h08;
            4'd5:    v = 8'h10;
            4'd6:    v = 8'h20;
            4'd7:    v = 8'h40;
            4'd8:    v = 8'h80;
            4'd9:    v = 8'h1b;
            4'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    state_e       fsm_q, fsm_d;
    logic [127:0] st_q, st_d;
    logic [127:0] rk_q, rk_d;
    logic [3:0]   rnd_q, rnd_d;

    // Key schedule runs beside the state path so both settle in the same cycle.
    logic [31:0]  w0, w1, w2, w3, t, n0, n1, n2, n3;
    logic [127:0] nk, sr, round_out;

    assign {w0, w1, w2, w3} = rk_q;
    assign t  = sub_word({w3[23:0], w3[31:24]}) ^ {rcon(rnd_q), 24'h0};
    assign n0 = w0 ^ t;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;
    assign nk = {n0, n1, n2, n3};

    assign sr        = shift_rows(sub_bytes(st_q));
    assign round_out = ((rnd_q == 4'd10) ? sr : mix_columns(sr)) ^ nk;

    always_comb begin
        fsm_d = fsm_q;
        st_d  = st_q;
        rk_d  = rk_q;
        rnd_d = rnd_q;
        unique case (fsm_q)
            StIdle: begin
                if (bus.in_valid) begin
                    st_d  = bus.plaintext ^ bus.key;
                    rk_d  = bus.key;
                    rnd_d = 4'd1;
                    fsm_d = StRun;
                end
            end
            StRun: begin
                st_d = round_out;
                rk_d = nk;
                if (rnd_q == 4'd10) fsm_d = StDone;
                else                rnd_d = rnd_q + 4'd1;
            end
            StDone: begin
                if (bus.out_ready) fsm_d = StIdle;
            end
            default: fsm_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q <= StIdle;
            st_q  <= '0;
            rk_q  <= '0;
            rnd_q <= '0;
        end else begin
            fsm_q <= fsm_d;
            st_q  <= st_d;
            rk_q  <= rk_d;
            rnd_q <= rnd_d;
        end
    end

    assign bus.in_ready   = (fsm_q == StIdle);
    assign bus.out_valid  = (fsm_q == StDone);
    assign bus.busy       = (fsm_q != StIdle);
    assign bus.ciphertext = st_q;
endmodule
